// File: rtl/seg_display_mux.sv
// seg_display_mux: sequential binary-to-BCD converter driving a multiplexed common-anode 7-segment display
//   clk, rst         : clock, synchronous active-high reset
//   data_i, mode_i   : magnitude and display mode (0 unsigned, 1 negative, 2 error, 3 fixed-point)
//   load_i, busy_o   : capture request; ignored while busy_o is high
//   anodes_o         : active-low one-hot digit enable
//   segments_o       : active-low {dp,g,f,e,d,c,b,a}
module seg_display_mux #(
  parameter int DATA_W  = 11,
  parameter int DIGITS  = 4,
  parameter int CNT     = 12,
  parameter int DOT_POS = 2,
  parameter int LZB     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_i,
  input  logic [1:0]        mode_i,
  input  logic              load_i,
  output logic              busy_o,
  output logic [DIGITS-1:0] anodes_o,
  output logic [7:0]        segments_o
);
  localparam int BCD_N = (3 * DATA_W) / 10 + 1;
  // one spare nibble keeps every constant shift below the vector width
  localparam int EXT = (BCD_N > DIGITS ? BCD_N : DIGITS) + 1;
  localparam int IW = DIGITS > 1 ? $clog2(DIGITS) : 1;
  localparam int SW = $clog2(DATA_W + 1);
  localparam logic [1:0] IDLE = 2'd0, SHIFT = 2'd1, COMMIT = 2'd2;
  logic [1:0]         state;
  logic [1:0]         mode;
  logic [DATA_W-1:0]  sh;
  logic [SW-1:0]      bits;
  logic [4*BCD_N-1:0] bcd, adj;
  logic [4*EXT-1:0]   bx;
  logic               ovf;
  logic [CNT-1:0]     pre;
  logic [IW-1:0]      idx;
  logic [7:0]         disp [DIGITS];
  logic [7:0]         nxt [DIGITS];
  function automatic logic [6:0] seg7(input logic [3:0] n);
    case (n)
      4'd0: return 7'b1000000;
      4'd1: return 7'b1111001;
      4'd2: return 7'b0100100;
      4'd3: return 7'b0110000;
      4'd4: return 7'b0011001;
      4'd5: return 7'b0010010;
      4'd6: return 7'b0000010;
      4'd7: return 7'b1111000;
      4'd8: return 7'b0000000;
      4'd9: return 7'b0010000;
      default: return 7'b1111111;
    endcase
  endfunction
  assign busy_o = state != IDLE;
  always_comb begin
    adj = bcd;
    for (int i = 0; i < BCD_N; i++)
      adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
  end
  // later rules override earlier ones: blanking, point, minus, then error/overflow
  always_comb begin
    bx = (4*EXT)'(bcd);
    ovf = mode == 2'd1 ? (bx >> (4*(DIGITS-1))) != '0 : (bx >> (4*DIGITS)) != '0;
    for (int i = 0; i < DIGITS; i++) begin
      nxt[i] = {1'b1, seg7(bx[4*i+:4])};
      if (LZB != 0 && i != 0 && (bx >> (4*i)) == '0 && !(mode == 2'd3 && i <= DOT_POS))
        nxt[i] = 8'hFF;
      if (mode == 2'd3 && i == DOT_POS) nxt[i][7] = 1'b0;
      if (mode == 2'd1 && i == DIGITS - 1) nxt[i] = 8'hBF;
      if (mode == 2'd2 || ovf) nxt[i] = i == 0 ? 8'h86 : 8'hFF;
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      mode       <= '0;
      sh         <= '0;
      bits       <= '0;
      bcd        <= '0;
      pre        <= '0;
      idx        <= '0;
      anodes_o   <= '1;
      segments_o <= 8'hFF;
      for (int i = 0; i < DIGITS; i++) disp[i] <= 8'hFF;
    end else begin
      pre        <= pre + 1'b1;
      if (&pre) idx <= idx == IW'(DIGITS - 1) ? '0 : idx + 1'b1;
      anodes_o   <= ~(DIGITS'(1) << idx);
      segments_o <= disp[idx];
      if (state == IDLE && load_i) begin
        state <= SHIFT;
        sh    <= data_i;
        mode  <= mode_i;
        bcd   <= '0;
        bits  <= '0;
      end else if (state == SHIFT) begin
        bcd  <= {adj[4*BCD_N-2:0], sh[DATA_W-1]};
        sh   <= sh << 1;
        bits <= bits + 1'b1;
        if (bits == SW'(DATA_W - 1)) state <= COMMIT;
      end else if (state == COMMIT) begin
        for (int i = 0; i < DIGITS; i++) disp[i] <= nxt[i];
        state <= IDLE;
      end
    end
  end
endmodule

// File: tb/tb_seg_display_mux.sv
// tb_seg_display_mux: scoreboard bench for seg_display_mux across three configurations
module tb_seg_display_mux;
  typedef logic [3:0][7:0] disp_t;
  typedef struct {disp_t a; disp_t b; disp_t c;} exp_t;
  localparam int DOT = 2;
  logic clk = 0, rst = 1, load = 0;
  logic [10:0] data = '0;
  logic [1:0] mode = '0;
  logic busy0, busy1, busy2;
  logic [3:0] an0, an1;
  logic [2:0] an2;
  logic [7:0] sg0, sg1, sg2;
  int checks = 0, errors = 0;
  exp_t q[$];
  logic [6:0] tbl [10] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
                           7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000};
  always #5 clk = ~clk;
  seg_display_mux #(.DATA_W(11), .DIGITS(4), .CNT(2), .DOT_POS(DOT), .LZB(1)) u0 (
    .clk(clk), .rst(rst), .data_i(data), .mode_i(mode), .load_i(load),
    .busy_o(busy0), .anodes_o(an0), .segments_o(sg0));
  seg_display_mux #(.DATA_W(11), .DIGITS(4), .CNT(2), .DOT_POS(DOT), .LZB(0)) u1 (
    .clk(clk), .rst(rst), .data_i(data), .mode_i(mode), .load_i(load),
    .busy_o(busy1), .anodes_o(an1), .segments_o(sg1));
  seg_display_mux #(.DATA_W(11), .DIGITS(3), .CNT(2), .DOT_POS(DOT), .LZB(1)) u2 (
    .clk(clk), .rst(rst), .data_i(data), .mode_i(mode), .load_i(load),
    .busy_o(busy2), .anodes_o(an2), .segments_o(sg2));
  function automatic disp_t model(input int v, input int m, input int nd, input int lzb);
    disp_t r;
    int lim, p;
    bit keep;
    r = '1;
    lim = m == 1 ? nd - 1 : nd;
    p = 1;
    for (int i = 0; i < lim; i++) p = p * 10;
    if (m == 2 || v >= p) begin
      r[0] = 8'h86;
      return r;
    end
    p = 1;
    for (int i = 0; i < lim; i++) begin
      keep = i == 0 || lzb == 0 || v >= p || (m == 3 && i <= DOT);
      r[i] = keep ? {!(m == 3 && i == DOT), tbl[(v / p) % 10]} : 8'hFF;
      p = p * 10;
    end
    if (m == 1) r[nd-1] = 8'hBF;
    return r;
  endfunction
  function automatic int decode(input logic [3:0] a, input int n);
    int z, k;
    z = 0;
    k = -1;
    for (int i = 0; i < 4; i++)
      if (!a[i]) begin
        z++;
        k = i;
      end
    return (z == 1 && k < n) ? k : -1;
  endfunction
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s got %h want %h", name, got, want);
    end
  endtask
  task automatic issue(input int v, input int m, input bit push);
    @(posedge clk);
    #1;
    data = 11'(v);
    mode = 2'(m);
    load = 1;
    if (push) q.push_back('{model(v, m, 4, 1), model(v, m, 4, 0), model(v, m, 3, 1)});
    @(posedge clk);
    #1;
    load = 0;
  endtask
  task automatic wait_idle();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy0 && n < 100);
    check("busy_timeout", {31'd0, busy0}, 32'd0);
    repeat (20) @(posedge clk);
  endtask
  // monitor: on each completed conversion, scan a full refresh cycle and compare every digit
  initial begin
    bit pb, pr;
    int blen, last [3], k [3];
    bit seen [3][4];
    logic [7:0] got [3][4];
    bit bad [3];
    exp_t e;
    disp_t w;
    pb = 0;
    pr = 1;
    blen = 0;
    forever begin
      @(negedge clk);
      if (pb && !busy0 && !pr) begin
        check("busy_len", blen, 32'd12);
        check("queue_nonempty", {31'd0, q.size() != 0}, 32'd1);
        if (q.size() != 0) begin
          e = q.pop_front();
          for (int u = 0; u < 3; u++) begin
            last[u] = -1;
            bad[u] = 0;
            for (int d = 0; d < 4; d++) seen[u][d] = 0;
          end
          repeat (17) begin
            @(negedge clk);
            k[0] = decode(an0, 4);
            k[1] = decode(an1, 4);
            k[2] = decode({1'b1, an2}, 3);
            for (int u = 0; u < 3; u++) begin
              if (k[u] < 0) bad[u] = 1;
              else begin
                if (last[u] >= 0 && k[u] != last[u] && k[u] != (last[u] + 1) % (u == 2 ? 3 : 4))
                  bad[u] = 1;
                last[u] = k[u];
                if (!seen[u][k[u]]) begin
                  seen[u][k[u]] = 1;
                  got[u][k[u]] = u == 0 ? sg0 : u == 1 ? sg1 : sg2;
                end
              end
            end
          end
          for (int u = 0; u < 3; u++) begin
            w = u == 0 ? e.a : u == 1 ? e.b : e.c;
            check($sformatf("anode_seq_u%0d", u), {31'd0, bad[u]}, 32'd0);
            for (int d = 0; d < (u == 2 ? 3 : 4); d++)
              check($sformatf("u%0d_digit%0d", u, d), seen[u][d] ? {24'd0, got[u][d]} : 32'hDEAD,
                    {24'd0, w[d]});
          end
        end
        blen = 0;
      end
      blen = busy0 ? blen + 1 : 0;
      pb = busy0;
      pr = rst;
    end
  end
  initial begin
    int dirs [7][2] = '{'{1234, 0}, '{7, 0}, '{45, 1}, '{1234, 1}, '{5, 3}, '{2047, 0}, '{1000, 0}};
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_busy", {29'd0, busy0, busy1, busy2}, 32'd0);
    check("reset_anodes", {21'd0, an0, an1, an2}, 32'h7FF);
    check("reset_segments", {8'd0, sg0, sg1, sg2}, 32'hFFFFFF);
    @(posedge clk);
    #1;
    rst = 0;
    for (int i = 0; i < 7; i++) begin
      issue(dirs[i][0], dirs[i][1], 1);
      wait_idle();
    end
    issue(321, 0, 1);
    repeat (3) @(posedge clk);
    #1;
    data = 11'd999;
    mode = 2'd3;
    load = 1;
    @(posedge clk);
    #1;
    load = 0;
    wait_idle();
    issue(555, 0, 0);
    repeat (4) @(posedge clk);
    #1;
    rst = 1;
    @(posedge clk);
    #1;
    rst = 0;
    @(negedge clk);
    check("abort_busy", {29'd0, busy0, busy1, busy2}, 32'd0);
    check("abort_anodes", {21'd0, an0, an1, an2}, 32'h7FF);
    check("abort_segments", {8'd0, sg0, sg1, sg2}, 32'hFFFFFF);
    repeat (9) @(negedge clk);
    check("blank_after_abort", {8'd0, sg0, sg1, sg2}, 32'hFFFFFF);
    for (int i = 0; i < 20; i++) begin
      issue($urandom_range(0, 2047), $urandom_range(0, 3), 1);
      wait_idle();
    end
    check("queue_drained", q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
